// File: rtl/sar_scan_sched_if.sv
// Signal bundle between the scan scheduler, its SAR ADC and the result consumer.
// Handshakes: adc_start/adc_eoc are single-cycle pulses (one eoc per start, adc_dout valid with eoc);
// res_valid, scan_done and err are single-cycle pulses with no backpressure, so the consumer must always accept.
interface sar_scan_sched_if #(
  parameter int ADC_WIDTH = 8,
  parameter int NCH       = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                 en;
  logic                 single;
  logic [NCH-1:0]       ch_mask;
  logic [CW-1:0]        mux_sel;
  logic                 adc_start;
  logic                 adc_eoc;
  logic [ADC_WIDTH-1:0] adc_dout;
  logic                 busy;
  logic                 res_valid;
  logic [CW-1:0]        res_ch;
  logic [ADC_WIDTH-1:0] res_data;
  logic                 scan_done;
  logic                 err;
  logic [2:0]           fsm_state;

  modport master (
    input  en, single, ch_mask, adc_eoc, adc_dout,
    output mux_sel, adc_start, busy, res_valid, res_ch, res_data, scan_done, err, fsm_state
  );

  modport slave (
    output en, single, ch_mask, adc_eoc, adc_dout,
    input  mux_sel, adc_start, busy, res_valid, res_ch, res_data, scan_done, err, fsm_state
  );
endinterface

// File: rtl/sar_scan_sched.sv
// Time-shares one SAR ADC across NCH inputs: mux select, settle, 2^AVG_LOG2 conversions
// per channel, averaged result per enabled channel, timeout detection on missing eoc.
module sar_scan_sched #(
  parameter int ADC_WIDTH = 8,
  parameter int NCH       = 4,
  parameter int SETTLE    = 3,
  parameter int AVG_LOG2  = 2,
  parameter int TMO       = 4
) (
  input  logic             clk,
  input  logic             rst,
  sar_scan_sched_if.master bus
);
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW    = ADC_WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SET_W = $clog2(SETTLE + 2);
  localparam int TMO_W = $clog2(ADC_WIDTH + TMO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  // tmo_cnt is 0 in the first CONV cycle, so err lands ADC_WIDTH+TMO cycles after adc_start
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ADC_WIDTH + TMO - 2);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_CONV, S_OUT, S_NEXT} state_t;

  state_t               state;
  logic [NCH-1:0]       mask_q;
  logic [CW-1:0]        mux_sel_q;
  logic [AW-1:0]        acc;
  logic [CNT_W-1:0]     smp_cnt;
  logic [SET_W-1:0]     settle_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 adc_start_q, busy_q, res_valid_q, scan_done_q, err_q;
  logic [CW-1:0]        res_ch_q;
  logic [ADC_WIDTH-1:0] res_data_q;

  logic                 first_found, next_found, trigger;
  logic [CW-1:0]        first_ch, next_ch;
  logic [AW-1:0]        acc_sum;

  // Downward loops so the lowest qualifying bit wins.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = CW'(i);
      end
      if (mask_q[i] && (i > int'(mux_sel_q))) begin
        next_found = 1'b1;
        next_ch    = CW'(i);
      end
    end
  end

  // The scan_done cycle is spent in IDLE with busy still high; only en may chain a new scan there.
  assign trigger = bus.en | (bus.single & ~scan_done_q);
  assign acc_sum = acc + AW'(bus.adc_dout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      mux_sel_q   <= '0;
      acc         <= '0;
      smp_cnt     <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      adc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      err_q       <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
    end else begin
      adc_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger && first_found) begin
            mask_q    <= bus.ch_mask;
            mux_sel_q <= first_ch;
            busy_q    <= 1'b1;
            if (SETTLE == 0) begin
              state       <= S_START;
              adc_start_q <= 1'b1;
            end else begin
              state      <= S_SETTLE;
              settle_cnt <= '0;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            state       <= S_START;
            adc_start_q <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_START: begin
          state   <= S_CONV;
          tmo_cnt <= '0;
        end
        S_CONV: begin
          if (bus.adc_eoc) begin
            acc <= acc_sum;
            if (smp_cnt != CNT_LAST) begin
              smp_cnt     <= smp_cnt + 1'b1;
              state       <= S_START;
              adc_start_q <= 1'b1;
            end else begin
              state       <= S_OUT;
              res_valid_q <= 1'b1;
              res_ch_q    <= mux_sel_q;
              res_data_q  <= acc_sum[AW-1:AVG_LOG2];
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err_q   <= 1'b1;
            acc     <= '0;
            smp_cnt <= '0;
            state   <= S_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_OUT: begin
          acc     <= '0;
          smp_cnt <= '0;
          state   <= S_NEXT;
        end
        S_NEXT: begin
          if (next_found) begin
            mux_sel_q <= next_ch;
            if (SETTLE == 0) begin
              state       <= S_START;
              adc_start_q <= 1'b1;
            end else begin
              state      <= S_SETTLE;
              settle_cnt <= '0;
            end
          end else begin
            scan_done_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mux_sel   = mux_sel_q;
  assign bus.adc_start = adc_start_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_data  = res_data_q;
  assign bus.scan_done = scan_done_q;
  assign bus.err       = err_q;
  assign bus.fsm_state = 3'(state);
endmodule
